// File: rtl/and_input_debounce.sv
// and_input_debounce
//   Two-channel switch debouncer feeding the two inputs of the AND gate stage.
//   Each channel: 2-flop synchroniser, then a 4-state FSM that only lets the
//   output follow the synchronised level after it has held for STABLE_CYCLES
//   consecutive cycles. Any reversal during a wait throws the count away.
//
//   Optional feature macro: AND_DEBOUNCE_EDGE_EN adds registered one-cycle
//   rising-edge pulses a_rise / b_rise. Level outputs are identical either way.
//
// Ports
//   clk     in   single clock, rising edge
//   rst     in   synchronous active-high reset
//   sw_a    in   raw switch level, channel A (async to clk)
//   sw_b    in   raw switch level, channel B (async to clk)
//   a       out  debounced level A
//   b       out  debounced level B
//   a_rise  out  one-cycle pulse on a 0->1   (AND_DEBOUNCE_EDGE_EN only)
//   b_rise  out  one-cycle pulse on b 0->1   (AND_DEBOUNCE_EDGE_EN only)

// One debounce lane: synchroniser + FSM + counter.
module and_input_debounce_ch #(
  parameter int STABLE_CYCLES = 50000,
  parameter int CNT_WIDTH     = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_sw,
`ifdef AND_DEBOUNCE_EDGE_EN
  output logic o_rise,
`endif
  output logic o_lvl
);

  typedef enum logic [1:0] {
    ST_LOW,
    ST_RISE_WAIT,
    ST_HIGH,
    ST_FALL_WAIT
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(STABLE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic                 r_s1, r_s2;
  state_t               r_state, w_nxt_state;
  logic [CNT_WIDTH-1:0] r_cnt, w_nxt_cnt;
  logic                 r_out, w_nxt_out;

  // Entering a wait state counts the current cycle as the first stable one,
  // so the count reaches CNT_MAX on the STABLE_CYCLES-th stable cycle.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cnt   = r_cnt;
    w_nxt_out   = r_out;
    case (r_state)
      ST_LOW: begin
        w_nxt_out = 1'b0;
        w_nxt_cnt = '0;
        if (r_s2) begin
          w_nxt_state = ST_RISE_WAIT;
          w_nxt_cnt   = CNT_ONE;
        end
      end
      ST_RISE_WAIT: begin
        w_nxt_out = 1'b0;
        if (!r_s2) begin
          w_nxt_state = ST_LOW;
          w_nxt_cnt   = '0;
        end else if (r_cnt == CNT_MAX) begin
          w_nxt_state = ST_HIGH;
          w_nxt_out   = 1'b1;
          w_nxt_cnt   = '0;
        end else begin
          w_nxt_cnt = r_cnt + CNT_ONE;
        end
      end
      ST_HIGH: begin
        w_nxt_out = 1'b1;
        w_nxt_cnt = '0;
        if (!r_s2) begin
          w_nxt_state = ST_FALL_WAIT;
          w_nxt_cnt   = CNT_ONE;
        end
      end
      ST_FALL_WAIT: begin
        w_nxt_out = 1'b1;
        if (r_s2) begin
          w_nxt_state = ST_HIGH;
          w_nxt_cnt   = '0;
        end else if (r_cnt == CNT_MAX) begin
          w_nxt_state = ST_LOW;
          w_nxt_out   = 1'b0;
          w_nxt_cnt   = '0;
        end else begin
          w_nxt_cnt = r_cnt + CNT_ONE;
        end
      end
      default: begin
        w_nxt_state = ST_LOW;
        w_nxt_cnt   = '0;
        w_nxt_out   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_state <= ST_LOW;
      r_cnt   <= '0;
      r_out   <= 1'b0;
    end else begin
      r_s1    <= i_sw;
      r_s2    <= r_s1;
      r_state <= w_nxt_state;
      r_cnt   <= w_nxt_cnt;
      r_out   <= w_nxt_out;
    end
  end

  assign o_lvl = r_out;

`ifdef AND_DEBOUNCE_EDGE_EN
  // Registered alongside r_out, so the pulse is high in the first cycle the
  // level reads 1.
  logic r_rise;
  always_ff @(posedge clk) begin
    if (rst) r_rise <= 1'b0;
    else     r_rise <= w_nxt_out & ~r_out;
  end
  assign o_rise = r_rise;
`endif

endmodule

module and_input_debounce #(
  parameter int STABLE_CYCLES = 50000,
  parameter int CNT_WIDTH     = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic sw_a,
  input  logic sw_b,
`ifdef AND_DEBOUNCE_EDGE_EN
  output logic a_rise,
  output logic b_rise,
`endif
  output logic a,
  output logic b
);

  localparam int NUM_LANES = 2;

  logic [NUM_LANES-1:0] w_sw;
  logic [NUM_LANES-1:0] w_lvl;
`ifdef AND_DEBOUNCE_EDGE_EN
  logic [NUM_LANES-1:0] w_rise;
`endif

  assign w_sw = {sw_b, sw_a};

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    and_input_debounce_ch #(
      .STABLE_CYCLES(STABLE_CYCLES),
      .CNT_WIDTH    (CNT_WIDTH)
    ) u_ch (
      .clk   (clk),
      .rst   (rst),
      .i_sw  (w_sw[g]),
`ifdef AND_DEBOUNCE_EDGE_EN
      .o_rise(w_rise[g]),
`endif
      .o_lvl (w_lvl[g])
    );
  end

  assign a = w_lvl[0];
  assign b = w_lvl[1];
`ifdef AND_DEBOUNCE_EDGE_EN
  assign a_rise = w_rise[0];
  assign b_rise = w_rise[1];
`endif

endmodule

// File: tb/tb_and_input_debounce.sv
module tb_and_input_debounce;
  localparam int SC = 4;
  localparam int CW = 3;

  logic clk, rst, sw_a, sw_b, a, b, c;
`ifdef AND_DEBOUNCE_EDGE_EN
  logic a_rise, b_rise;
`endif

  int checks = 0;
  int failures = 0;

  // reference model: synchroniser pipeline plus a run length of cycles in
  // which the synchronised level disagrees with the output
  logic m_s1 [2];
  logic m_s2 [2];
  logic m_out[2];
  logic m_rise[2];
  int   m_run[2];

  and_input_debounce #(.STABLE_CYCLES(SC), .CNT_WIDTH(CW)) dut (
    .clk   (clk),
    .rst   (rst),
    .sw_a  (sw_a),
    .sw_b  (sw_b),
`ifdef AND_DEBOUNCE_EDGE_EN
    .a_rise(a_rise),
    .b_rise(b_rise),
`endif
    .a     (a),
    .b     (b)
  );

  // downstream AND gate stage
  assign c = a & b;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input logic va, input logic vb, input logic vr);
    logic sw;
    sw_a = va; sw_b = vb; rst = vr;
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      sw = (i == 0) ? va : vb;
      m_rise[i] = 1'b0;
      if (vr) begin
        m_s1[i] = 0; m_s2[i] = 0; m_out[i] = 0; m_run[i] = 0;
      end else begin
        if (m_s2[i] != m_out[i]) begin
          m_run[i]++;
          if (m_run[i] == SC) begin
            m_out[i] = ~m_out[i];
            m_run[i] = 0;
            m_rise[i] = m_out[i];
          end
        end else m_run[i] = 0;
        m_s2[i] = m_s1[i];
        m_s1[i] = sw;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      tick(1'($urandom), 1'($urandom), 1'b1);
      checks++;
      if (a !== 1'b0 || b !== 1'b0) begin
        failures++;
        $display("FAIL reset_out a=%b b=%b expected 0 0", a, b);
      end
    end
  endtask

  task automatic test_clean_rise();
    int rises = 0;
    do_reset();
    for (int e = 1; e <= 10; e++) begin
      tick(1'b1, 1'b0, 1'b0);
      checks++;
      if (a !== (e >= 6) || a !== m_out[0] || b !== 1'b0) begin
        failures++;
        $display("FAIL clean_rise edge=%0d a=%b b=%b expected a=%b b=0", e, a, b, e >= 6);
      end
`ifdef AND_DEBOUNCE_EDGE_EN
      if (a_rise === 1'b1) rises++;
      checks++;
      if (a_rise !== (e == 6) || b_rise !== 1'b0) begin
        failures++;
        $display("FAIL clean_rise_pulse edge=%0d a_rise=%b b_rise=%b expected %b 0", e, a_rise, b_rise, e == 6);
      end
`endif
    end
    checks++;
`ifdef AND_DEBOUNCE_EDGE_EN
    if (rises != 1) begin
      failures++;
      $display("FAIL clean_rise_count pulses=%0d expected 1", rises);
    end
`else
    if (rises != 0) begin
      failures++;
      $display("FAIL clean_rise_count pulses=%0d expected 0", rises);
    end
`endif
  endtask

  task automatic test_bounce();
    logic lvl;
    do_reset();
    for (int e = 0; e < 24; e++) begin
      lvl = ((e / 2) % 2) == 0;
      tick(lvl, 1'b0, 1'b0);
      checks++;
      if (a !== 1'b0 || a !== m_out[0]) begin
        failures++;
        $display("FAIL bounce_hold cyc=%0d a=%b expected 0", e, a);
      end
    end
    for (int e = 1; e <= 9; e++) begin
      tick(1'b1, 1'b0, 1'b0);
      checks++;
      if (a !== (e >= 6) || a !== m_out[0]) begin
        failures++;
        $display("FAIL bounce_settle edge=%0d a=%b expected %b", e, a, e >= 6);
      end
    end
  endtask

  task automatic test_glitch();
    int lows = 0;
    do_reset();
    for (int e = 0; e < 10; e++) tick(1'b1, 1'b0, 1'b0);
    for (int e = 0; e < 13; e++) begin
      tick((e < 3) ? 1'b0 : 1'b1, 1'b0, 1'b0);
      checks++;
      if (a !== 1'b1 || a !== m_out[0]) begin
        failures++;
        $display("FAIL glitch3_level cyc=%0d a=%b expected 1", e, a);
      end
`ifdef AND_DEBOUNCE_EDGE_EN
      checks++;
      if (a_rise !== 1'b0) begin
        failures++;
        $display("FAIL glitch3_pulse cyc=%0d a_rise=%b expected 0", e, a_rise);
      end
`endif
    end
    for (int e = 0; e < 16; e++) begin
      tick((e < 4) ? 1'b0 : 1'b1, 1'b0, 1'b0);
      if (a === 1'b0) lows++;
      checks++;
      if (a !== m_out[0]) begin
        failures++;
        $display("FAIL glitch4_model cyc=%0d a=%b expected %b", e, a, m_out[0]);
      end
    end
    checks++;
    if (lows < 1 || a !== 1'b1) begin
      failures++;
      $display("FAIL glitch4_dip low_cycles=%0d final_a=%b expected >=1 and 1", lows, a);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int e = 1; e <= 4; e++) tick(1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b1);
    checks++;
    if (b !== 1'b0 || dut.g_lane[1].u_ch.r_cnt !== 3'd0) begin
      failures++;
      $display("FAIL reset_mid_clear b=%b cnt=%0d expected 0 0", b, dut.g_lane[1].u_ch.r_cnt);
    end
    for (int e = 1; e <= 8; e++) begin
      tick(1'b0, 1'b1, 1'b0);
      checks++;
      if (b !== (e >= 6) || b !== m_out[1]) begin
        failures++;
        $display("FAIL reset_mid_release edge=%0d b=%b expected %b", e, b, e >= 6);
      end
    end
  endtask

  task automatic test_independent();
    do_reset();
    for (int e = 1; e <= 12; e++) begin
      tick(1'b1, (e == 4) ? 1'b0 : 1'b1, 1'b0);
      checks++;
      if (a !== (e >= 6) || b !== (e >= 10) || a !== m_out[0] || b !== m_out[1]) begin
        failures++;
        $display("FAIL independent edge=%0d a=%b b=%b expected %b %b", e, a, b, e >= 6, e >= 10);
      end
      checks++;
      if (c !== (e >= 10)) begin
        failures++;
        $display("FAIL and_gate edge=%0d c=%b expected %b", e, c, e >= 10);
      end
    end
  endtask

  task automatic test_random();
    logic va = 0, vb = 0, vr;
    int ha = 0, hb = 0;
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if (ha == 0) begin va = 1'($urandom); ha = $urandom_range(1, 7); end
      if (hb == 0) begin vb = 1'($urandom); hb = $urandom_range(1, 7); end
      ha--; hb--;
      vr = ($urandom_range(0, 99) == 0);
      tick(va, vb, vr);
      checks++;
      if (a !== m_out[0] || b !== m_out[1] || c !== (m_out[0] & m_out[1])) begin
        failures++;
        $display("FAIL random n=%0d a=%b b=%b c=%b expected %b %b %b", n, a, b, c,
                 m_out[0], m_out[1], m_out[0] & m_out[1]);
      end
`ifdef AND_DEBOUNCE_EDGE_EN
      checks++;
      if (a_rise !== m_rise[0] || b_rise !== m_rise[1]) begin
        failures++;
        $display("FAIL random_pulse n=%0d a_rise=%b b_rise=%b expected %b %b", n, a_rise, b_rise,
                 m_rise[0], m_rise[1]);
      end
`endif
    end
  endtask

  initial begin
    rst = 1'b1; sw_a = 1'b0; sw_b = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_s1[i] = 0; m_s2[i] = 0; m_out[i] = 0; m_rise[i] = 0; m_run[i] = 0;
    end
    test_reset();
    test_clean_rise();
    test_bounce();
    test_glitch();
    test_reset_mid();
    test_independent();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
